// File: rtl/transmissor_jogada.sv
// UART-style transmitter for one completed move: encodes the one-hot macro/micro cells into a byte
// {micro_idx, macro_idx} and shifts it out. Optional even-parity bit enabled by defining PARIDADE_EN.
module transmissor_jogada #(
   parameter int unsigned CICLOS_POR_BIT = 434
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       envia,
   input  logic [8:0] macro,
   input  logic [8:0] micro,
   output logic       saida_serial,
   output logic       pronto,
   output logic       erro,
   output logic [3:0] db_estado
);

   localparam int unsigned BAUD_W = (CICLOS_POR_BIT > 1) ? $clog2(CICLOS_POR_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CICLOS_POR_BIT - 1);

   typedef enum logic [3:0] {
      OCIOSO   = 4'd0,
      START    = 4'd1,
      DADOS    = 4'd2,
      PARIDADE = 4'd3,
      STOP     = 4'd4
   } estado_t;

   estado_t           estado, estado_n;
   logic [BAUD_W-1:0] baud, baud_n;
   logic [2:0]        nbit, nbit_n;
   logic [7:0]        dado, dado_n;
   logic              saida_n, pronto_n, erro_n;
   logic [7:0]        quadro;
   logic              ops_ok;
   logic              fim_bit;
`ifdef PARIDADE_EN
   logic              paridade, paridade_n;
`endif

   // Exactly one bit set; zero or multiple bits is an invalid operand.
   function automatic logic valido(input logic [8:0] v);
      return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
   endfunction

   function automatic logic [3:0] indice(input logic [8:0] v);
      logic [3:0] r;
      r = 4'd0;
      for (int k = 0; k < 9; k++) begin
         if (v[k]) r = 4'(k);
      end
      return r;
   endfunction

   assign ops_ok    = valido(macro) && valido(micro);
   assign quadro    = {indice(micro), indice(macro)};
   assign fim_bit   = (baud == BAUD_MAX);
   assign db_estado = estado;

   // State and registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado       <= OCIOSO;
         baud         <= '0;
         nbit         <= 3'd0;
         dado         <= 8'd0;
         saida_serial <= 1'b1;
         pronto       <= 1'b1;
         erro         <= 1'b0;
`ifdef PARIDADE_EN
         paridade     <= 1'b0;
`endif
      end else begin
         estado       <= estado_n;
         baud         <= baud_n;
         nbit         <= nbit_n;
         dado         <= dado_n;
         saida_serial <= saida_n;
         pronto       <= pronto_n;
         erro         <= erro_n;
`ifdef PARIDADE_EN
         paridade     <= paridade_n;
`endif
      end
   end

   // Next state plus the next value of every registered output.
   always_comb begin
      estado_n = estado;
      baud_n   = baud;
      nbit_n   = nbit;
      dado_n   = dado;
      saida_n  = saida_serial;
      pronto_n = pronto;
      erro_n   = erro;
`ifdef PARIDADE_EN
      paridade_n = paridade;
`endif

      if (estado != OCIOSO) begin
         baud_n = fim_bit ? '0 : baud + BAUD_W'(1);
      end

      case (estado)
         OCIOSO: begin
            saida_n  = 1'b1;
            pronto_n = 1'b1;
            baud_n   = '0;
            nbit_n   = 3'd0;
            if (envia) begin
               if (ops_ok) begin
                  estado_n = START;
                  dado_n   = quadro;
                  erro_n   = 1'b0;
                  saida_n  = 1'b0;
                  pronto_n = 1'b0;
`ifdef PARIDADE_EN
                  paridade_n = ^quadro;
`endif
               end else begin
                  erro_n = 1'b1;
               end
            end
         end
         START: begin
            if (fim_bit) begin
               estado_n = DADOS;
               saida_n  = dado[0];
            end
         end
         DADOS: begin
            if (fim_bit) begin
               if (nbit == 3'd7) begin
                  nbit_n = 3'd0;
`ifdef PARIDADE_EN
                  estado_n = PARIDADE;
                  saida_n  = paridade;
`else
                  estado_n = STOP;
                  saida_n  = 1'b1;
`endif
               end else begin
                  nbit_n  = nbit + 3'd1;
                  dado_n  = {1'b0, dado[7:1]};
                  saida_n = dado[1];
               end
            end
         end
         PARIDADE: begin
`ifdef PARIDADE_EN
            if (fim_bit) begin
               estado_n = STOP;
               saida_n  = 1'b1;
            end
`else
            estado_n = OCIOSO;
            saida_n  = 1'b1;
            pronto_n = 1'b1;
`endif
         end
         STOP: begin
            if (fim_bit) begin
               estado_n = OCIOSO;
               saida_n  = 1'b1;
               pronto_n = 1'b1;
            end
         end
         default: begin
            estado_n = OCIOSO;
            saida_n  = 1'b1;
            pronto_n = 1'b1;
         end
      endcase
   end

endmodule

// File: doc/transmissor_jogada.md
# transmissor_jogada

Serial transmitter for a completed move (one macro cell plus one micro cell of the ultimate tic-tac-toe board). Takes the 9-bit one-hot macro and micro selections captured by the game datapath, encodes each into a 4-bit cell index, and sends them as one UART-style frame to the remote board or PC. It is the outbound side of the move path: the datapath captures button presses, and this block ships the captured move off-chip.

## Interface
Parameters:
- CICLOS_POR_BIT, default 434: clock cycles per serial bit (50 MHz / 115200 baud); minimum 2.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- envia  input  1  request to transmit; sampled only while `pronto`=1.
- macro  input  9  one-hot macro cell (bit k = cell k).
- micro  input  9  one-hot micro cell.
- saida_serial  output  1  serial line; idles high.
- pronto  output  1  high while idle and able to accept `envia`.
- erro  output  1  last request was rejected (operand not one-hot).
- db_estado  output  4  current FSM state code, for debug.

## Operation
- Encoding: one-hot bit k gives index k (0..8). An all-zero operand or an operand with more than one bit set is invalid.
- Frame byte: {micro_idx[3:0], macro_idx[3:0]}.
- Frame order: start bit (0), then 8 data bits LSB first, then an optional parity bit, then a stop bit (1).
- FSM state codes:
  - OCIOSO=0
  - START=1
  - DADOS=2
  - PARIDADE=3
  - STOP=4
- OCIOSO:
  - `pronto`=1 and `saida_serial`=1.
  - `envia`=1 with both operands valid: latch the byte and go to START. Also clears `erro`.
  - `envia`=1 with either operand invalid: stay in OCIOSO, set `erro`=1 and send nothing.
- START: drive 0 for CICLOS_POR_BIT cycles, then go to DADOS.
- DADOS:
  - Drive the shift register LSB for CICLOS_POR_BIT cycles, then shift.
  - A 3-bit counter counts 8 bits.
  - After bit 7, go to PARIDADE if the parity feature is compiled in, otherwise to STOP.
- PARIDADE: drive the even-parity bit (XOR of the 8 data bits) for CICLOS_POR_BIT cycles, then go to STOP.
- STOP: drive 1 for CICLOS_POR_BIT cycles, then go to OCIOSO.
- Inputs are latched at acceptance. Changes to `macro`, `micro` or `envia` mid-frame are ignored.
- `erro` is sticky. It is cleared only by reset or by the next accepted request.
- Baud counter width is $clog2(CICLOS_POR_BIT). It wraps to 0 at CICLOS_POR_BIT-1.

## Timing
- Reset values:
  - State = OCIOSO.
  - `saida_serial`=1, `pronto`=1, `erro`=0, `db_estado`=0.
  - Counters = 0.
- Acceptance: `envia` is sampled at rising edge N. From edge N onward, `saida_serial`=0 and `pronto`=0; both are registered outputs.
- Each bit is held for exactly CICLOS_POR_BIT cycles.
- Frame length: 10·CICLOS_POR_BIT cycles, or 11·CICLOS_POR_BIT with parity.
- `pronto` returns to 1 on the edge that ends the stop bit. A new request can be accepted on the very next edge, giving back-to-back frames with no idle gap.
- `envia` held high continuously: one frame is sent per idle window. No edge detection is done here; the caller pulses `envia`.
- Rejected request: `erro` rises at edge N, and `pronto` stays 1.
- `envia` while `pronto`=0 is dropped silently and does not set `erro`.
- Reset asserted mid-frame: the line returns to 1 immediately (asynchronous) and the partial frame is abandoned.

## Configuration
- PARIDADE_EN defined: the PARIDADE state exists and frames carry an even-parity bit (11 bits per frame).
- PARIDADE_EN undefined: DADOS goes directly to STOP, frames are 10 bits, and state code 3 is never reached.

## Test plan
All scenarios use CICLOS_POR_BIT=4.
- Reset, then idle: `saida_serial`=1, `pronto`=1, `erro`=0, `db_estado`=0.
- macro=9'b000010000, micro=9'b000000001, `envia` pulse:
  - Byte 0x04; line reads 0, then 0,0,1,0,0,0,0,0.
  - With PARIDADE_EN: parity bit 1.
  - Then stop bit 1.
  - `pronto` is low for 40 cycles (44 with parity).
- macro=micro=9'b100000000: byte 0x88; data bits 0,0,0,1,0,0,0,1; parity 0 when enabled.
- macro=9'b000000011, `envia` pulse: `erro`=1, line stays 1, `pronto` stays 1. A following valid request sends a frame and clears `erro`.
- `envia` held high with changing operands during a frame: exactly one frame carrying the latched value, followed by a second frame starting the cycle after the stop bit ends.
- Reset pulsed during DADOS bit 3: `saida_serial`=1 and `db_estado`=0 immediately. A new request then sends a full frame correctly.
